hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline hazard controller for the 5-stage MIPS core, sitting beside the EX-stage forwarding unit and driving the hold and flush controls of the PC, IF/ID and ID/EX registers. It covers the hazards forwarding cannot resolve:

- load-use dependencies
- multi-cycle MULT/DIV occupancy of the HI/LO unit
- taken-branch flushes

It also keeps a saturating count of stall cycles for performance measurement.

## Interface
Parameters:
- MD_LATENCY, 32, cycles the MULT/DIV unit is busy after issue (legal range 2..255)
- CNT_W, 16, width of stall counter

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rs_id  in  5  rs field of instruction in ID
- rt_id  in  5  rt field of instruction in ID
- uses_rs_id  in  1  ID instruction reads rs
- uses_rt_id  in  1  ID instruction reads rt
- memRead_exe  in  1  instruction in EX is a load
- outReg_exe  in  5  destination register of instruction in EX
- nop_exe  in  1  EX holds a bubble
- md_start_id  in  1  ID instruction is MULT/MULTU/DIV/DIVU
- hilo_read_id  in  1  ID instruction is MFHI/MFLO
- branch_taken_exe  in  1  branch/jump in EX resolved taken
- stall_pc  out  1  hold PC
- stall_ifid  out  1  hold IF/ID register
- bubble_idex  out  1  load NOP into ID/EX
- flush_ifid  out  1  replace IF/ID contents with NOP
- md_issue  out  1  start pulse to MULT/DIV unit
- md_busy  out  1  MULT/DIV unit occupied
- md_done  out  1  one-cycle completion pulse
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
The FSM has two states, RUN and MD_BUSY, backed by an 8-bit down-counter md_cnt.

Combinational hazard terms (Mealy, from the current inputs and the registered state):
- lu = memRead_exe & ~nop_exe & outReg_exe≠0 & ((uses_rs_id & rs_id==outReg_exe) | (uses_rt_id & rt_id==outReg_exe))
- mdh = (state==MD_BUSY) & (hilo_read_id | md_start_id)
- stall = ~branch_taken_exe & (lu | mdh)

Outputs:
- stall_pc = stall_ifid = stall
- bubble_idex = stall | branch_taken_exe
- flush_ifid = branch_taken_exe
- md_issue = (state==RUN) & md_start_id & ~stall & ~branch_taken_exe

Priority: a flush always wins. A taken branch suppresses stall and md_issue, because the stalled or issuing instruction is on the wrong path.

Transitions:
- RUN → MD_BUSY on md_issue; md_cnt ← MD_LATENCY-1.
- MD_BUSY: md_cnt decrements by 1 each cycle. At the edge where md_cnt==0, go to RUN and set md_done for exactly one cycle.
- A branch flush in MD_BUSY does not abort the operation; the issued MULT/DIV is older than the branch.
- A new md_start_id in MD_BUSY stalls in ID until RUN, then issues normally. It may issue in the same cycle md_done is high.

md_busy = (state==MD_BUSY), registered. HI/LO are written by the MULT/DIV unit at the edge leaving MD_BUSY, so hilo_read_id proceeds whenever md_busy=0.

stall_count increments by 1 on every cycle where stall=1 and saturates at 2^CNT_W-1; it never wraps.

## Timing
- Reset (asynchronous, rst_n low): state=RUN, md_cnt=0, md_busy=0, md_done=0, stall_count=0. The combinational outputs then depend only on inputs, with mdh=0.
- Reset asserted mid-MD_BUSY aborts the operation immediately; no md_done pulse is produced.
- A load-use stall lasts exactly 1 cycle. After the hold, the load is in MEM and the bubble is in EX, so lu=0 and the forwarding unit supplies the value.
- md_issue in cycle T → md_busy high in cycles T+1 .. T+MD_LATENCY → md_done high in cycle T+MD_LATENCY+1.
- A load-use hazard and mdh in the same cycle produce a single stall; stall_count increments by 1.
- outReg_exe==0 never causes a stall.

## Test plan
- Load-use: EX = LW to $5 (memRead_exe=1), ID uses rs=$5 → stall_pc=stall_ifid=bubble_idex=1 for exactly 1 cycle, stall_count 0→1. Repeat with outReg_exe=0 or nop_exe=1 → no stall.
- MULT issue with MD_LATENCY=4: md_start_id at T → md_issue=1 at T; md_busy high T+1..T+4; md_done high only at T+5. An MFLO in ID from T+1 stalls 4 cycles and proceeds at T+5.
- Branch priority: branch_taken_exe=1 together with a load-use match → flush_ifid=1, bubble_idex=1, stall_pc=0, stall_count unchanged. With md_start_id also in ID → md_issue=0.
- Back-to-back DIVs: second md_start_id while busy stalls, then issues in the md_done cycle; md_busy is low for exactly that one cycle between the two operations.
- Reset mid-operation: rst_n low at busy cycle 2 → md_busy=0 and state=RUN immediately; no md_done pulse after release.
- Saturation with CNT_W=4: 20 continuous stall cycles → stall_count holds at 15.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Hazard controller for the 5-stage MIPS core. It covers the hazards that
// forwarding cannot resolve: load-use, MULT/DIV occupancy of HI/LO, and
// taken-branch flushes. It also keeps a saturating stall-cycle counter.
//
// State table:
//   state   | meaning
//   RUN     | MULT/DIV unit idle, ID may issue MULT/DIV or read HI/LO
//   MD_BUSY | MULT/DIV in flight, md_cnt counts remaining busy cycles
//
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   rs_id, rt_id        source fields of the ID instruction
//   uses_rs_id/rt_id    ID instruction actually reads rs / rt
//   memRead_exe         EX instruction is a load
//   outReg_exe          EX destination register
//   nop_exe             EX holds a bubble
//   md_start_id         ID instruction is MULT/MULTU/DIV/DIVU
//   hilo_read_id        ID instruction is MFHI/MFLO
//   branch_taken_exe    branch/jump in EX resolved taken
//   stall_pc, stall_ifid, bubble_idex, flush_ifid   pipeline controls
//   md_issue, md_busy, md_done                      MULT/DIV handshake
//   stall_count         saturating count of stall cycles
module hazard_stall_ctrl #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic             uses_rs_id,
    input  logic             uses_rt_id,
    input  logic             memRead_exe,
    input  logic [4:0]       outReg_exe,
    input  logic             nop_exe,
    input  logic             md_start_id,
    input  logic             hilo_read_id,
    input  logic             branch_taken_exe,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             bubble_idex,
    output logic             flush_ifid,
    output logic             md_issue,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    state_t     state, state_next;
    logic [7:0] md_cnt, md_cnt_next;
    logic       md_done_next;
    logic       lu, mdh, stall;

    // Register 0 is hardwired zero, so a load "to $0" never creates a hazard.
    assign lu = memRead_exe & ~nop_exe & (outReg_exe != 5'd0) &
                ((uses_rs_id & (rs_id == outReg_exe)) |
                 (uses_rt_id & (rt_id == outReg_exe)));

    assign mdh = (state == MD_BUSY) & (hilo_read_id | md_start_id);

    // A taken branch squashes the ID instruction, so it must not stall or issue.
    assign stall = ~branch_taken_exe & (lu | mdh);

    assign stall_pc    = stall;
    assign stall_ifid  = stall;
    assign bubble_idex = stall | branch_taken_exe;
    assign flush_ifid  = branch_taken_exe;
    assign md_issue    = (state == RUN) & md_start_id & ~stall & ~branch_taken_exe;
    assign md_busy     = (state == MD_BUSY);

    always_comb begin
        state_next   = state;
        md_cnt_next  = md_cnt;
        md_done_next = 1'b0;
        case (state)
            RUN: begin
                if (md_issue) begin
                    state_next  = MD_BUSY;
                    md_cnt_next = 8'(MD_LATENCY - 1);
                end
            end
            MD_BUSY: begin
                // Branch flushes are ignored here: the MULT/DIV is older.
                if (md_cnt == 8'd0) begin
                    state_next   = RUN;
                    md_done_next = 1'b1;
                end else begin
                    md_cnt_next = md_cnt - 8'd1;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            md_cnt  <= 8'd0;
            md_done <= 1'b0;
        end else begin
            state   <= state_next;
            md_cnt  <= md_cnt_next;
            md_done <= md_done_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl (MD_LATENCY=4, CNT_W=4).
// Directed scenarios followed by randomized traffic, all compared each cycle
// against a reference model that tracks "busy cycles remaining" as an integer.
module tb_hazard_stall_ctrl;

    localparam int LAT   = 4;
    localparam int CW    = 4;
    localparam int SAT   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    rs_id, rt_id, outReg_exe;
    logic          uses_rs_id, uses_rt_id, memRead_exe, nop_exe;
    logic          md_start_id, hilo_read_id, branch_taken_exe;
    logic          stall_pc, stall_ifid, bubble_idex, flush_ifid;
    logic          md_issue, md_busy, md_done;
    logic [CW-1:0] stall_count;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int m_rem;
    bit m_done;
    int m_cnt;

    hazard_stall_ctrl #(.MD_LATENCY(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_id(rs_id), .rt_id(rt_id),
        .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id),
        .memRead_exe(memRead_exe), .outReg_exe(outReg_exe), .nop_exe(nop_exe),
        .md_start_id(md_start_id), .hilo_read_id(hilo_read_id),
        .branch_taken_exe(branch_taken_exe),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid),
        .bubble_idex(bubble_idex), .flush_ifid(flush_ifid),
        .md_issue(md_issue), .md_busy(md_busy), .md_done(md_done),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rem  = 0;
        m_done = 0;
        m_cnt  = 0;
    endtask

    task automatic idle();
        rs_id = 0; rt_id = 0; outReg_exe = 0;
        uses_rs_id = 0; uses_rt_id = 0; memRead_exe = 0; nop_exe = 0;
        md_start_id = 0; hilo_read_id = 0; branch_taken_exe = 0;
    endtask

    // Check one cycle at the falling edge, then advance the model across the
    // rising edge. Returns #1 after the rising edge, ready for new inputs.
    task automatic cycle();
        bit busy, lu, mdh, st, iss;
        @(negedge clk);
        busy = (m_rem > 0);
        lu   = memRead_exe && !nop_exe && (outReg_exe != 0) &&
               ((uses_rs_id && rs_id == outReg_exe) || (uses_rt_id && rt_id == outReg_exe));
        mdh  = busy && (hilo_read_id || md_start_id);
        st   = !branch_taken_exe && (lu || mdh);
        iss  = !busy && md_start_id && !st && !branch_taken_exe;
        chk("stall_pc",    32'(stall_pc),    32'(st));
        chk("stall_ifid",  32'(stall_ifid),  32'(st));
        chk("bubble_idex", 32'(bubble_idex), 32'(st || branch_taken_exe));
        chk("flush_ifid",  32'(flush_ifid),  32'(branch_taken_exe));
        chk("md_issue",    32'(md_issue),    32'(iss));
        chk("md_busy",     32'(md_busy),     32'(busy));
        chk("md_done",     32'(md_done),     32'(m_done));
        chk("stall_count", 32'(stall_count), 32'(m_cnt));
        if (iss) begin
            m_rem  = LAT;
            m_done = 0;
        end else if (m_rem > 0) begin
            m_rem  = m_rem - 1;
            m_done = (m_rem == 0);
        end else begin
            m_done = 0;
        end
        if (st && m_cnt < SAT) m_cnt = m_cnt + 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  32'(md_busy),     32'd0);
        chk("rst_done",  32'(md_done),     32'd0);
        chk("rst_count", 32'(stall_count), 32'd0);
        rst_n = 1'b1;

        // load-use on rs=$5, then bubble in EX
        memRead_exe = 1; outReg_exe = 5; rs_id = 5; uses_rs_id = 1;
        cycle();
        memRead_exe = 0; nop_exe = 1;
        cycle();
        chk("lu_count", 32'(stall_count), 32'd1);
        // $0 destination and bubble in EX never stall
        nop_exe = 0; memRead_exe = 1; outReg_exe = 0; rs_id = 0; rt_id = 0; uses_rt_id = 1;
        cycle();
        outReg_exe = 7; rt_id = 7; nop_exe = 1;
        cycle();
        chk("no_lu_count", 32'(stall_count), 32'd1);

        // MULT issue, then MFLO held for the busy window
        idle();
        md_start_id = 1;
        cycle();
        md_start_id = 0; hilo_read_id = 1;
        repeat (LAT + 1) cycle();
        hilo_read_id = 0;
        cycle();
        chk("mult_count", 32'(stall_count), 32'd5);

        // taken branch beats load-use and MULT issue
        memRead_exe = 1; outReg_exe = 9; rs_id = 9; uses_rs_id = 1;
        md_start_id = 1; branch_taken_exe = 1;
        cycle();
        idle();
        chk("br_count", 32'(stall_count), 32'd5);
        chk("br_busy",  32'(md_busy),     32'd0);

        // back-to-back DIVs: second issues in the md_done cycle
        md_start_id = 1;
        repeat (LAT + 2) cycle();
        md_start_id = 0;
        repeat (LAT + 2) cycle();
        chk("b2b_count", 32'(stall_count), 32'd9);

        // reset in busy cycle 2 aborts without md_done
        md_start_id = 1;
        cycle();
        md_start_id = 0;
        cycle();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_busy",  32'(md_busy),     32'd0);
        chk("midrst_count", 32'(stall_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (LAT + 2) cycle();

        // saturation
        memRead_exe = 1; outReg_exe = 3; rt_id = 3; uses_rt_id = 1;
        repeat (20) cycle();
        chk("sat_count", 32'(stall_count), 32'(SAT));
        idle();
        cycle();

        // randomized traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            rs_id            = 5'($urandom_range(0, 3));
            rt_id            = 5'($urandom_range(0, 3));
            outReg_exe       = 5'($urandom_range(0, 3));
            uses_rs_id       = 1'($urandom);
            uses_rt_id       = 1'($urandom);
            memRead_exe      = 1'($urandom);
            nop_exe          = ($urandom_range(0, 4) == 0);
            md_start_id      = ($urandom_range(0, 3) == 0);
            hilo_read_id     = ($urandom_range(0, 3) == 0);
            branch_taken_exe = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                chk("rnd_rst_busy", 32'(md_busy), 32'd0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
